machine_display_scan: RTL and testbench
=======================================

// Module: machine_display_scan
// PURPOSE
//   Parametrised successor to the fixed 4-digit display path: captures tagged data words
//   from the machine core into N_CHAN hold registers and time-multiplexes one channel
//   onto an N_DIGITS common-anode 7-segment display. Adds auto/manual channel rotation,
//   tear-free snapshots, a channel-index decimal point and "----" for never-written channels.
//   Sits between the machine core output stage and the board display pins.
// PARAMETERS
//   N_CHAN    4        number of data channels held (>=1)
//   N_DIGITS  4        hex digits per channel; data width = 4*N_DIGITS
//   SCAN_DIV  1000     clock cycles each digit stays lit (>=2)
//   DWELL     1000000  clock cycles per channel in auto mode (>=2)
// PORTS
//   system1000       in   1                 clock
//   system1000_rstn  in   1                 asynchronous reset, active low
//   in_valid         in   1                 write strobe for in_data/in_chan
//   in_chan          in   max(1,clog2(N_CHAN))  target channel of write
//   in_data          in   4*N_DIGITS        word to hold, digit 0 = bits[3:0]
//   auto_mode        in   1                 1 = rotate channels every DWELL, 0 = manual
//   sel_next         in   1                 level; rising edge advances channel in manual mode
//   cur_chan         out  max(1,clog2(N_CHAN))  channel currently displayed
//   result           out  N_DIGITS+8        {an[N_DIGITS-1:0], dp, seg[6:0]} all active low
// BEHAVIOUR
//   Reset (async, rstn=0): hold regs=0, written flags=0, snapshot=0, scan/dwell counters=0,
//     digit index=0, cur_chan=0, sel_next history=0, result=all ones (display dark).
//   Write: in_valid=1 and in_chan<N_CHAN -> hold[in_chan]<=in_data, written[in_chan]<=1 next edge.
//     in_chan>=N_CHAN: write ignored, no state change.
//   Scan: scan_cnt counts 0..SCAN_DIV-1 and wraps; on wrap digit index advances mod N_DIGITS.
//   Snapshot: when digit index wraps N_DIGITS-1 -> 0, snap<=hold[cur_chan] and
//     snap_ok<=written[cur_chan]; a write in the same cycle is NOT in that snapshot.
//     Displayed digits never mix two values within one frame.
//   Channel select: auto_mode=1 -> dwell_cnt 0..DWELL-1, on wrap cur_chan<=(cur_chan+1)%N_CHAN.
//     auto_mode=0 -> dwell_cnt held 0; registered rising edge of sel_next advances cur_chan.
//     sel_next edges while auto_mode=1 ignored. Any change of auto_mode clears dwell_cnt.
//     A channel change forces an immediate snapshot of the new channel and digit index=0,
//     scan_cnt=0 (new channel visible from the next cycle's frame start).
//   Output (registered, 1-cycle latency from digit index/snapshot):
//     an: only bit [digit index] low. seg: hex font of snap nibble[digit index]
//     (0-9,A-F, standard gfedcba, active low); if snap_ok=0, seg = only g lit (7'b0111111).
//     dp low iff digit index == cur_chan % N_DIGITS, else high.
//   Reset asserted mid-frame: outputs go dark asynchronously; after release the first frame
//     starts at digit 0, channel 0, showing "----" until a write plus snapshot occurs.
//   N_CHAN=1: cur_chan fixed 0, sel_next and dwell wrap have no effect.
// TESTING (N_CHAN=4, N_DIGITS=4, SCAN_DIV=4, DWELL=64 in bench)
//   1 Reset then run 20 cycles, no writes -> result=all ones during reset; then each digit
//     shows seg=7'b0111111, an walks 1110,1101,1011,0111 every 4 cycles, dp low on digit 0.
//   2 Write chan0=16'h1A2F, wait for frame start -> digits show F,2,A,1 (seg 0001110,
//     0100100,0001000,1111001) on an 1110..0111.
//   3 Write chan0=16'h0000 mid-frame (digit 2) -> current frame keeps 1A2F digits;
//     next frame shows all 0 (seg 1000000).
//   4 auto_mode=1, chans 0..3 written 1111/2222/3333/4444 -> cur_chan steps 0,1,2,3,0 every
//     64 cycles; display switches at the step; dp moves to digit=cur_chan.
//   5 auto_mode=0, pulse sel_next high 10 cycles twice -> cur_chan advances exactly 2;
//     write with in_chan out of range impossible at N_CHAN=4, so rerun N_CHAN=3 with
//     in_chan=3 -> no channel changes.
//   6 Assert rstn low at digit 2 of an active frame -> result all ones same cycle
//     (async); release -> digit 0, cur_chan 0, "----" shown.

Source files
------------

// File: rtl/machine_display_scan.sv
// Multi-channel hold registers time-multiplexed onto a common-anode
// 7-segment display, with auto/manual channel rotation and tear-free frames.
module machine_display_scan #(
  parameter int N_CHAN   = 4,
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DWELL    = 1000000,
  localparam int CW  = (N_CHAN > 1) ? $clog2(N_CHAN) : 1,
  localparam int DW  = 4 * N_DIGITS
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                in_valid,
  input  logic [CW-1:0]       in_chan,
  input  logic [DW-1:0]       in_data,
  input  logic                auto_mode,
  input  logic                sel_next,
  output logic [CW-1:0]       cur_chan,
  output logic [N_DIGITS+7:0] result
);

  localparam int DIW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int TW  = $clog2(DWELL);

  logic [DW-1:0]     hold [N_CHAN];
  logic [N_CHAN-1:0] written;
  logic [DW-1:0]     snap;
  logic              snap_ok;
  logic [SW-1:0]     scan_cnt;
  logic [DIW-1:0]    dig;
  logic [TW-1:0]     dwell_cnt;
  logic              sel_q;
  logic              auto_q;

  logic              wr_ok;
  logic              dwell_wrap;
  logic              sel_rise;
  logic              step;
  logic              scan_wrap;
  logic              dig_last;
  logic [CW-1:0]     nxt_chan;
  logic [DW-1:0]     nxt_data;
  logic              nxt_ok;
  logic [DW-1:0]     cur_data;
  logic              cur_ok;
  logic [3:0]        nib;
  logic [N_DIGITS-1:0] an_n;
  logic              dp_n;
  logic [6:0]        seg_n;

  assign wr_ok = in_valid &&
                 ({1'b0, in_chan} < (CW+1)'(N_CHAN));

  assign dwell_wrap = auto_mode && auto_q &&
                      (dwell_cnt == TW'(DWELL - 1));

  assign sel_rise = !auto_mode && sel_next && !sel_q;

  assign step = (N_CHAN > 1) &&
                (auto_mode ? dwell_wrap : sel_rise);

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));
  assign dig_last  = (dig == DIW'(N_DIGITS - 1));

  assign nxt_chan = (cur_chan == CW'(N_CHAN - 1)) ?
                    '0 : cur_chan + 1'b1;

  // Select hold data for the current and the following channel
  always_comb begin
    nxt_data = '0;
    nxt_ok   = 1'b0;
    cur_data = '0;
    cur_ok   = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (nxt_chan == CW'(i)) begin
        nxt_data = hold[i];
        nxt_ok   = written[i];
      end
      if (cur_chan == CW'(i)) begin
        cur_data = hold[i];
        cur_ok   = written[i];
      end
    end
  end

  // Capture tagged words into the per-channel hold registers
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int i = 0; i < N_CHAN; i++) hold[i] <= '0;
      written <= '0;
    end else begin
      for (int i = 0; i < N_CHAN; i++) begin
        if (wr_ok && in_chan == CW'(i)) begin
          hold[i]    <= in_data;
          written[i] <= 1'b1;
        end
      end
    end
  end

  // Channel selection: dwell timer in auto mode, sel_next edges in manual
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      dwell_cnt <= '0;
      cur_chan  <= '0;
      sel_q     <= 1'b0;
      auto_q    <= 1'b0;
    end else begin
      sel_q  <= sel_next;
      auto_q <= auto_mode;
      if (!auto_mode || auto_mode != auto_q || dwell_wrap)
        dwell_cnt <= '0;
      else
        dwell_cnt <= dwell_cnt + 1'b1;
      if (step)
        cur_chan <= nxt_chan;
    end
  end

  // Digit scan; snapshot taken only at frame start or on channel change
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      scan_cnt <= '0;
      dig      <= '0;
      snap     <= '0;
      snap_ok  <= 1'b0;
    end else if (step) begin
      scan_cnt <= '0;
      dig      <= '0;
      snap     <= nxt_data;
      snap_ok  <= nxt_ok;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      if (dig_last) begin
        dig     <= '0;
        snap    <= cur_data;
        snap_ok <= cur_ok;
      end else begin
        dig <= dig + 1'b1;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Anode, decimal point and nibble for the lit digit
  always_comb begin
    nib  = '0;
    an_n = '1;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (dig == DIW'(d)) begin
        nib     = snap[4*d +: 4];
        an_n[d] = 1'b0;
      end
    end
    dp_n = !(dig == DIW'(int'(cur_chan) % N_DIGITS));
  end

  // Hex font, active low gfedcba; dash when channel never written
  always_comb begin
    seg_n = 7'b0111111;
    if (snap_ok) begin
      unique case (nib)
        4'h0: seg_n = 7'b1000000;
        4'h1: seg_n = 7'b1111001;
        4'h2: seg_n = 7'b0100100;
        4'h3: seg_n = 7'b0110000;
        4'h4: seg_n = 7'b0011001;
        4'h5: seg_n = 7'b0010010;
        4'h6: seg_n = 7'b0000010;
        4'h7: seg_n = 7'b1111000;
        4'h8: seg_n = 7'b0000000;
        4'h9: seg_n = 7'b0010000;
        4'hA: seg_n = 7'b0001000;
        4'hB: seg_n = 7'b0000011;
        4'hC: seg_n = 7'b1000110;
        4'hD: seg_n = 7'b0100001;
        4'hE: seg_n = 7'b0000110;
        4'hF: seg_n = 7'b0001110;
      endcase
    end
  end

  // Registered display pins; dark during reset
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn)
      result <= '1;
    else
      result <= {an_n, dp_n, seg_n};
  end

endmodule

// File: tb/tb_machine_display_scan.sv
// Directed bench for machine_display_scan: frame timing, snapshots,
// channel rotation, out-of-range writes and async reset.
module tb_machine_display_scan;

  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SF   = 7'b0001110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_chan = '0;
  logic [15:0] in_data = '0;
  logic        auto_mode = 1'b0;
  logic        sel_next = 1'b0;
  logic [1:0]  cur_chan;
  logic [11:0] result;

  logic        in_valid3 = 1'b0;
  logic [1:0]  in_chan3 = '0;
  logic        auto3 = 1'b0;
  logic        sel3 = 1'b0;
  logic [1:0]  cur_chan3;
  logic [11:0] result3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  machine_display_scan #(
    .N_CHAN(4), .N_DIGITS(4), .SCAN_DIV(4), .DWELL(64)
  ) u_dut (
    .system1000(clk),
    .system1000_rstn(rst_n),
    .in_valid(in_valid),
    .in_chan(in_chan),
    .in_data(in_data),
    .auto_mode(auto_mode),
    .sel_next(sel_next),
    .cur_chan(cur_chan),
    .result(result)
  );

  machine_display_scan #(
    .N_CHAN(3), .N_DIGITS(4), .SCAN_DIV(4), .DWELL(64)
  ) u_dut3 (
    .system1000(clk),
    .system1000_rstn(rst_n),
    .in_valid(in_valid3),
    .in_chan(in_chan3),
    .in_data(in_data),
    .auto_mode(auto3),
    .sel_next(sel3),
    .cur_chan(cur_chan3),
    .result(result3)
  );

  typedef struct {
    int          at;
    bit          wr;
    logic [15:0] wd;
    bit          ck;
    logic [11:0] exp;
    string       nm;
  } vec_t;

  vec_t tv[$];

  function automatic logic [11:0] dsp(int d, int ch, logic [6:0] s);
    logic [3:0] an;
    an = 4'b1111;
    an[d] = 1'b0;
    return {an, (d == ch % 4) ? 1'b0 : 1'b1, s};
  endfunction

  function automatic vec_t ck(int at, logic [11:0] e, string nm);
    vec_t v;
    v.at = at; v.wr = 1'b0; v.wd = '0;
    v.ck = 1'b1; v.exp = e; v.nm = nm;
    return v;
  endfunction

  function automatic vec_t wr(int at, logic [15:0] d, string nm);
    vec_t v;
    v.at = at; v.wr = 1'b1; v.wd = d;
    v.ck = 1'b0; v.exp = '0; v.nm = nm;
    return v;
  endfunction

  task automatic chk(string nm, logic [11:0] got, logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic wait_until(int c);
    int g = 0;
    while (cyc < c && g < 20000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != c) begin
      checks++;
      errors++;
      $display("FAIL timing: at cyc %0d want %0d", cyc, c);
    end
  endtask

  logic [6:0] segc [4];

  initial begin
    segc = '{S1, S2, S3, S4};

    tv.push_back(ck(2,  dsp(0, 0, DASH), "dash_d0"));
    tv.push_back(ck(6,  dsp(1, 0, DASH), "dash_d1"));
    tv.push_back(ck(10, dsp(2, 0, DASH), "dash_d2"));
    tv.push_back(ck(14, dsp(3, 0, DASH), "dash_d3"));
    tv.push_back(ck(18, dsp(0, 0, DASH), "dash_f1"));
    tv.push_back(wr(20, 16'h1A2F, "w1a2f"));
    tv.push_back(ck(34, dsp(0, 0, SF), "f2_d0"));
    tv.push_back(ck(38, dsp(1, 0, S2), "f2_d1"));
    tv.push_back(ck(42, dsp(2, 0, SA), "f2_d2"));
    tv.push_back(ck(46, dsp(3, 0, S1), "f2_d3"));
    tv.push_back(ck(50, dsp(0, 0, SF), "f3_d0"));
    tv.push_back(ck(54, dsp(1, 0, S2), "f3_d1"));
    tv.push_back(wr(57, 16'h0000, "w0000"));
    tv.push_back(ck(58, dsp(2, 0, SA), "tear_d2"));
    tv.push_back(ck(62, dsp(3, 0, S1), "tear_d3"));
    tv.push_back(ck(66, dsp(0, 0, S0), "f4_d0"));
    tv.push_back(ck(70, dsp(1, 0, S0), "f4_d1"));
    tv.push_back(ck(74, dsp(2, 0, S0), "f4_d2"));
    tv.push_back(ck(78, dsp(3, 0, S0), "f4_d3"));

    repeat (3) @(negedge clk);
    chk("rst_dark", result, 12'hFFF);
    chk("rst_chan", {10'b0, cur_chan}, 12'd0);
    chk("rst_dark3", result3, 12'hFFF);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      wait_until(tv[i].at);
      if (tv[i].ck) chk(tv[i].nm, result, tv[i].exp);
      if (tv[i].wr) begin
        in_valid = 1'b1;
        in_chan  = 2'd0;
        in_data  = tv[i].wd;
        @(negedge clk);
        in_valid = 1'b0;
      end
    end

    wait_until(81);
    in_valid3 = 1'b1;
    in_chan3  = 2'd3;
    in_data   = 16'h1234;
    @(negedge clk);
    in_valid3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_chan  = 2'(c);
      in_data  = {4{4'(c + 1)}};
      @(negedge clk);
    end
    in_valid = 1'b0;

    wait_until(90);
    auto_mode = 1'b1;

    wait_until(114);
    chk("n3_oor_dash", result3, dsp(0, 0, DASH));
    chk("n3_chan", {10'b0, cur_chan3}, 12'd0);

    for (int k = 1; k <= 4; k++) begin
      int w;
      int ch;
      w  = 155 + 64 * (k - 1);
      ch = k % 4;
      wait_until(w - 1);
      chk($sformatf("auto_pre%0d", k), {10'b0, cur_chan},
          12'((k - 1) % 4));
      wait_until(w);
      chk($sformatf("auto_step%0d", k), {10'b0, cur_chan}, 12'(ch));
      wait_until(w + 2);
      chk($sformatf("auto_d0_%0d", k), result, dsp(0, ch, segc[ch]));
      if (ch != 0) begin
        wait_until(w + 4 * ch + 2);
        chk($sformatf("auto_dp_%0d", k), result,
            dsp(ch, ch, segc[ch]));
      end
    end

    wait_until(360);
    sel_next = 1'b1;
    wait_until(363);
    sel_next = 1'b0;
    wait_until(366);
    chk("auto_sel_ign", {10'b0, cur_chan}, 12'd0);

    wait_until(370);
    auto_mode = 1'b0;
    wait_until(380);
    sel_next = 1'b1;
    wait_until(381);
    chk("man_step1", {10'b0, cur_chan}, 12'd1);
    wait_until(390);
    chk("man_hold1", {10'b0, cur_chan}, 12'd1);
    sel_next = 1'b0;
    wait_until(400);
    sel_next = 1'b1;
    wait_until(401);
    chk("man_step2", {10'b0, cur_chan}, 12'd2);
    wait_until(402);
    chk("man_d0", result, dsp(0, 2, S3));
    wait_until(410);
    chk("man_d2_dp", result, dsp(2, 2, S3));
    chk("man_hold2", {10'b0, cur_chan}, 12'd2);

    sel_next = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_dark", result, 12'hFFF);
    chk("async_chan", {10'b0, cur_chan}, 12'd0);
    repeat (2) @(negedge clk);
    chk("rst2_dark", result, 12'hFFF);
    rst_n = 1'b1;
    wait_until(2);
    chk("rel_d0", result, dsp(0, 0, DASH));
    wait_until(6);
    chk("rel_d1", result, dsp(1, 0, DASH));
    wait_until(18);
    chk("rel_f1", result, dsp(0, 0, DASH));
    chk("rel_chan", {10'b0, cur_chan}, 12'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
